calc_key_encoder: RTL
=====================

# calc_key_encoder

- Scans a 4x4 calculator keypad, debounces presses, and encodes each accepted key into a 4-bit code plus a 2-bit key class (number / operator / equals / clear).
- Produces the input-event stream that feeds the calculator's operand/operator sequencing state table.
- Sits between the keypad pins and the calculator control path, and presents one key event at a time on a valid/ready handshake.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled; must be ≥ 2.
- DEBOUNCE_CYC, 20000: consecutive stable cycles required to accept a press or a release; must be ≥ 1.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- row_i  in  4  keypad rows; active-low with external pull-ups; asynchronous to clk.
- col_o  out  4  keypad column drive; active-low one-hot.
- key_valid_o  out  1  key event pending.
- key_code_o  out  4  key code, valid while key_valid_o is high.
- key_class_o  out  2  key class: 00 NUM, 01 OP, 10 EQ, 11 CLR.
- key_ready_i  in  1  consumer accepts the event when key_valid_o & key_ready_i.
- overrun_o  out  1  sticky flag: a key was dropped because the output slot was full.

## Operation
- row_i passes through a 2-flop synchronizer; all decisions use the synchronized rows (rs).
- Key map (row r, col c):
  - row 0: 1, 2, 3, ADD
  - row 1: 4, 5, 6, SUB
  - row 2: 7, 8, 9, AND
  - row 3: CLR, 0, EQ, OR
- Codes:
  - NUM: code = digit value.
  - OP: ADD=0, SUB=1, AND=2, OR=3.
  - EQ and CLR: code = 0.
- FSM states: SCAN, DB_PRESS, HOLD, DB_RELEASE.
- SCAN:
  - Drive column c for SCAN_DIV cycles.
  - Sample rs on the last cycle of the dwell.
  - If any row is low: latch c and the lowest-index low row, then go to DB_PRESS with col_o frozen.
  - Otherwise advance c (wraps 3→0).
- DB_PRESS:
  - Counter increments while the latched row stays low.
  - Latched row goes high: return to SCAN and advance the column.
  - Counter reaches DEBOUNCE_CYC-1: emit the key, go to HOLD.
- Emit:
  - Slot empty, or freed this same cycle by key_ready_i: load code and class, set valid.
  - Slot full: drop the key and set overrun_o.
- HOLD: stay while the latched row is low; on the first high sample go to DB_RELEASE.
- DB_RELEASE:
  - Counter increments while the row stays high.
  - Any low sample returns to HOLD; no second emit.
  - Counter reaches DEBOUNCE_CYC-1: go to SCAN and advance the column.
- Handshake:
  - key_valid_o, key_code_o and key_class_o stay stable until accepted.
  - key_ready_i while key_valid_o is low is ignored.
- overrun_o clears only on reset.
- Reset state:
  - FSM in SCAN on column 0, col_o=4'b1110.
  - All counters 0.
  - key_valid_o=0, key_code_o=0, key_class_o=0, overrun_o=0.
  - Reset asserted mid-debounce or mid-hold aborts immediately; no event is emitted.

## Timing
- A press that is stable from the sample point produces key_valid_o high 2 (synchronizer) + DEBOUNCE_CYC + 1 cycles after the sampled edge.
- key_valid_o falls on the cycle after the cycle in which key_valid_o & key_ready_i is seen.
- Exactly one event per physical press, whatever the hold duration.

## Configuration
- DEBOUNCE_EN:
  - Defined: debounce as described above.
  - Undefined: DB_PRESS emits on the cycle after the press is detected, DB_RELEASE returns to SCAN on the first high sample, and no debounce counter is synthesized; DEBOUNCE_CYC is ignored.

## Structure
- Shared package `calc_pkg`:
  - key-class enum (KEY_NUM, KEY_OP, KEY_EQ, KEY_CLR).
  - Op-code constants OP_ADD, OP_SUB, OP_AND, OP_OR.
  - The FSM state enum.
- Sub-module `calc_key_map`: combinational map from {row, col} to {class, code}.
- The FSM, counters, synchronizer and output slot live in the top module.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYC=8.
- Hold row 1 low when column 2 is driven for 40 cycles, key_ready_i=1 → exactly one event: class 00, code 6; col_o frozen at 4'b1011 during hold.
- Bounce: row 0 low for 3 cycles, then high, on column 3 → no event; scan resumes at column 0.
- key_ready_i=0; press 5, release, then press EQ → first event held (class 00, code 5); EQ dropped; overrun_o=1.
- Rows 1 and 3 low together on column 0 → class 00, code 4 (lowest row wins).
- Release with glitches shorter than 8 cycles during DB_RELEASE → returns to HOLD; no duplicate event.
- Assert rst_n low mid-DB_PRESS → all outputs at reset values asynchronously; col_o=4'b1110 after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad encoder: key classes, operator codes,
// scanner FSM states and the row-priority helper. Used with or without DEBOUNCE_EN.
package calc_pkg;

    typedef enum logic [1:0] {
        KEY_NUM = 2'b00,
        KEY_OP  = 2'b01,
        KEY_EQ  = 2'b10,
        KEY_CLR = 2'b11
    } key_class_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DB_PRESS,
        ST_HOLD,
        ST_DB_RELEASE
    } kbd_state_t;

    // Rows are active-low; the lowest-numbered pressed row wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] row;
        row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) row = 2'(i);
        end
        return row;
    endfunction

endpackage

// File: rtl/calc_key_map.sv
// Combinational keypad map: latched {row, col} position to key class and 4-bit code.
module calc_key_map
    import calc_pkg::*;
(
    input  logic [1:0] i_row,
    input  logic [1:0] i_col,
    output key_class_t o_class,
    output logic [3:0] o_code
);

    always_comb begin
        o_class = KEY_NUM;
        o_code  = 4'd0;
        if (i_col == 2'd3) begin
            o_class = KEY_OP;
            case (i_row)
                2'd0:    o_code = OP_ADD;
                2'd1:    o_code = OP_SUB;
                2'd2:    o_code = OP_AND;
                default: o_code = OP_OR;
            endcase
        end else if (i_row == 2'd3) begin
            case (i_col)
                2'd0:    o_class = KEY_CLR;
                2'd1:    o_class = KEY_NUM;
                default: o_class = KEY_EQ;
            endcase
        end else begin
            // Digits 1..9 fill rows 0..2 left to right.
            o_code = {2'b00, i_row} * 4'd3 + {2'b00, i_col} + 4'd1;
        end
    end

endmodule

// File: rtl/calc_key_encoder.sv
// 4x4 calculator keypad scanner/encoder with a one-entry valid/ready output slot.
// Build option DEBOUNCE_EN: defined = counted press/release debounce; undefined = no counter.
//
// state         | meaning
// SCAN          | drive one column per dwell, sample rows at dwell end
// DB_PRESS      | column frozen, confirming the latched row stays low
// HOLD          | key emitted (or dropped), waiting for the row to rise
// DB_RELEASE    | confirming the row stays high before scanning resumes
module calc_key_encoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic [1:0] key_class_o,
    input  logic       key_ready_i,
    output logic       overrun_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CYC < 1) begin : g_bad_param
        $error("calc_key_encoder: SCAN_DIV must be >= 2 and DEBOUNCE_CYC >= 1");
    end

    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    kbd_state_t       r_state;
    logic [1:0]       r_col;
    logic [1:0]       r_row;
    logic [DIV_W-1:0] r_div;
    logic             r_valid;
    logic [3:0]       r_code;
    key_class_t       r_class;
    logic             r_overrun;

    logic             w_row_low;
    logic             w_emit;
    key_class_t       w_class;
    logic [3:0]       w_code;

`ifdef DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    logic [DB_W-1:0] r_db;
`endif

    // Synchronizer idles high so a released keypad never looks pressed after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_i;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_row_low = ~r_row_s2[r_row];

`ifdef DEBOUNCE_EN
    assign w_emit = (r_state == ST_DB_PRESS) && w_row_low && (r_db == DB_LAST);
`else
    assign w_emit = (r_state == ST_DB_PRESS);
`endif

    calc_key_map u_key_map (
        .i_row   (r_row),
        .i_col   (r_col),
        .o_class (w_class),
        .o_code  (w_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_div   <= '0;
`ifdef DEBOUNCE_EN
            r_db    <= '0;
`endif
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (r_row_s2 != 4'hF) begin
                            r_row   <= lowest_low_row(r_row_s2);
                            r_state <= ST_DB_PRESS;
`ifdef DEBOUNCE_EN
                            r_db    <= '0;
`endif
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_DB_PRESS: begin
`ifdef DEBOUNCE_EN
                    if (!w_row_low) begin
                        r_state <= ST_SCAN;
                        r_col   <= r_col + 2'd1;
                    end else if (r_db == DB_LAST) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_db <= r_db + DB_W'(1);
                    end
`else
                    r_state <= ST_HOLD;
`endif
                end
                ST_HOLD: begin
                    if (!w_row_low) begin
                        r_state <= ST_DB_RELEASE;
`ifdef DEBOUNCE_EN
                        r_db    <= '0;
`endif
                    end
                end
                ST_DB_RELEASE: begin
                    if (w_row_low) begin
                        r_state <= ST_HOLD;
`ifdef DEBOUNCE_EN
                    end else if (r_db == DB_LAST) begin
                        r_state <= ST_SCAN;
                        r_col   <= r_col + 2'd1;
                    end else begin
                        r_db <= r_db + DB_W'(1);
                    end
`else
                    end else begin
                        r_state <= ST_SCAN;
                        r_col   <= r_col + 2'd1;
                    end
`endif
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    // A slot being accepted this cycle may be refilled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_code    <= 4'd0;
            r_class   <= KEY_NUM;
            r_overrun <= 1'b0;
        end else if (w_emit) begin
            if (!r_valid || key_ready_i) begin
                r_valid <= 1'b1;
                r_code  <= w_code;
                r_class <= w_class;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && key_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign col_o       = ~(4'b0001 << r_col);
    assign key_valid_o = r_valid;
    assign key_code_o  = r_code;
    assign key_class_o = r_class;
    assign overrun_o   = r_overrun;

endmodule
